// File: rtl/id_ex_pipe_reg_pkg.sv
// ============================================================================
// Module      : id_ex_pipe_reg_pkg
// Description : Shared constants and helpers for the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_ex_pipe_reg_pkg;

    // Bit positions inside the one-hot forwarding select
    localparam int FORWARD_NO_COLLISION     = 0;
    localparam int FORWARD_COLLISION_IN_MEM = 1;
    localparam int FORWARD_COLLISION_IN_WB  = 2;

    localparam logic [1:0] ALU_SEL_REG    = 2'd0;
    localparam logic [1:0] ALU_SEL_PC_IMM = 2'd1;
    localparam logic [1:0] ALU_SEL_ZERO   = 2'd2;

    typedef logic [2:0] fwd_sel_t;

    localparam fwd_sel_t FWD_SEL_RESET = 3'b001;

    // The younger producer (the instruction about to enter MEM) wins over WB
    function automatic fwd_sel_t fwd_onehot(input logic hit_mem, input logic hit_wb);
        fwd_sel_t sel;
        sel = '0;
        if (hit_mem) begin
            sel[FORWARD_COLLISION_IN_MEM] = 1'b1;
        end else if (hit_wb) begin
            sel[FORWARD_COLLISION_IN_WB] = 1'b1;
        end else begin
            sel[FORWARD_NO_COLLISION] = 1'b1;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_pipe_reg_fwd_select_reg.sv
// ============================================================================
// Module      : fwd_select_reg
// Description : Per-operand forwarding select and held register-file operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_select_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_ex,
    input  logic                      i_reg_write_ex,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_mem,
    input  logic                      i_reg_write_mem,
    input  logic [DATA_WIDTH-1:0]     i_result_wb,
    output logic [2:0]                o_fwd_sel,
    output logic [DATA_WIDTH-1:0]     o_rd_data
);

    fwd_sel_t              r_sel_q;
    fwd_sel_t              w_sel_d;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [DATA_WIDTH-1:0] w_data_d;
    logic                  w_hit_ex;
    logic                  w_hit_mem;

    // A nonzero rd never matches rs==0, so x0 always resolves to NONE
    assign w_hit_ex  = i_reg_write_ex  && (i_rd_ex  != '0) && (i_rd_ex  == i_rs);
    assign w_hit_mem = i_reg_write_mem && (i_rd_mem != '0) && (i_rd_mem == i_rs);

    always_comb begin
        w_sel_d  = r_sel_q;
        w_data_d = r_data_q;
        if (i_flush) begin
            w_sel_d  = FWD_SEL_RESET;
            w_data_d = '0;
        end else if (i_stall) begin
            // Downstream keeps moving under a stall: MEM ages to WB, WB retires
            w_sel_d = '0;
            w_sel_d[FORWARD_COLLISION_IN_WB] = r_sel_q[FORWARD_COLLISION_IN_MEM];
            w_sel_d[FORWARD_NO_COLLISION]    = ~r_sel_q[FORWARD_COLLISION_IN_MEM];
            if (r_sel_q[FORWARD_COLLISION_IN_WB]) begin
                w_data_d = i_result_wb;
            end
        end else begin
            w_sel_d  = fwd_onehot(w_hit_ex, w_hit_mem);
            w_data_d = i_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q  <= FWD_SEL_RESET;
            r_data_q <= '0;
        end else begin
            r_sel_q  <= w_sel_d;
            r_data_q <= w_data_d;
        end
    end

    assign o_fwd_sel = r_sel_q;
    assign o_rd_data = r_data_q;

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register with precomputed forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_ID_EX,
    input  logic                      flush_ID_EX,
    input  logic [DATA_WIDTH-1:0]     PC_IF_ID_o,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     imm_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ID,
    input  logic [1:0]                alu_sel_rs1_ID,
    input  logic [1:0]                alu_sel_rs2_ID,
    input  logic [3:0]                alu_ctrl_ID,
    input  logic                      reg_write_ID,
    input  logic                      mem_read_ID,
    input  logic                      mem_write_ID,
    input  logic [1:0]                result_src_ID,
    input  logic                      valid_ID,
    input  logic [REG_ADDR_WIDTH-1:0] rd_EX_MEM_o,
    input  logic                      reg_write_EX_MEM_o,
    input  logic [DATA_WIDTH-1:0]     result_WB,
    output logic [DATA_WIDTH-1:0]     PC_ID_EX_o,
    output logic [DATA_WIDTH-1:0]     RD1D_ID_EX_o,
    output logic [DATA_WIDTH-1:0]     RD2D_ID_EX_o,
    output logic [DATA_WIDTH-1:0]     imm_ID_EX_o,
    output logic [REG_ADDR_WIDTH-1:0] rs1_ID_EX_o,
    output logic [REG_ADDR_WIDTH-1:0] rs2_ID_EX_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_ID_EX_o,
    output logic [1:0]                alu_sel_rs1_ID_EX_o,
    output logic [1:0]                alu_sel_rs2_ID_EX_o,
    output logic [3:0]                alu_ctrl_ID_EX_o,
    output logic                      reg_write_ID_EX_o,
    output logic                      mem_read_ID_EX_o,
    output logic                      mem_write_ID_EX_o,
    output logic                      valid_ID_EX_o,
    output logic [1:0]                result_src_ID_EX_o,
    output logic [2:0]                forward_detect_EX_rs1,
    output logic [2:0]                forward_detect_EX_rs2
);

    logic [DATA_WIDTH-1:0]     r_pc_q,        w_pc_d;
    logic [DATA_WIDTH-1:0]     r_imm_q,       w_imm_d;
    logic [REG_ADDR_WIDTH-1:0] r_rs1_q,       w_rs1_d;
    logic [REG_ADDR_WIDTH-1:0] r_rs2_q,       w_rs2_d;
    logic [REG_ADDR_WIDTH-1:0] r_rd_q,        w_rd_d;
    logic [1:0]                r_alu_sel1_q,  w_alu_sel1_d;
    logic [1:0]                r_alu_sel2_q,  w_alu_sel2_d;
    logic [3:0]                r_alu_ctrl_q,  w_alu_ctrl_d;
    logic                      r_reg_write_q, w_reg_write_d;
    logic                      r_mem_read_q,  w_mem_read_d;
    logic                      r_mem_write_q, w_mem_write_d;
    logic [1:0]                r_res_src_q,   w_res_src_d;
    logic                      r_valid_q,     w_valid_d;

    always_comb begin
        w_pc_d        = r_pc_q;
        w_imm_d       = r_imm_q;
        w_rs1_d       = r_rs1_q;
        w_rs2_d       = r_rs2_q;
        w_rd_d        = r_rd_q;
        w_alu_sel1_d  = r_alu_sel1_q;
        w_alu_sel2_d  = r_alu_sel2_q;
        w_alu_ctrl_d  = r_alu_ctrl_q;
        w_reg_write_d = r_reg_write_q;
        w_mem_read_d  = r_mem_read_q;
        w_mem_write_d = r_mem_write_q;
        w_res_src_d   = r_res_src_q;
        w_valid_d     = r_valid_q;
        if (flush_ID_EX) begin
            w_pc_d        = '0;
            w_imm_d       = '0;
            w_rs1_d       = '0;
            w_rs2_d       = '0;
            w_rd_d        = '0;
            w_alu_sel1_d  = ALU_SEL_REG;
            w_alu_sel2_d  = ALU_SEL_REG;
            w_alu_ctrl_d  = '0;
            w_reg_write_d = 1'b0;
            w_mem_read_d  = 1'b0;
            w_mem_write_d = 1'b0;
            w_res_src_d   = '0;
            w_valid_d     = 1'b0;
        end else if (!stall_ID_EX) begin
            w_pc_d        = PC_IF_ID_o;
            w_imm_d       = imm_ID;
            w_rs1_d       = rs1_ID;
            w_rs2_d       = rs2_ID;
            w_rd_d        = rd_ID;
            w_alu_sel1_d  = alu_sel_rs1_ID;
            w_alu_sel2_d  = alu_sel_rs2_ID;
            w_alu_ctrl_d  = alu_ctrl_ID;
            w_reg_write_d = reg_write_ID;
            w_mem_read_d  = mem_read_ID;
            w_mem_write_d = mem_write_ID;
            w_res_src_d   = result_src_ID;
            w_valid_d     = valid_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q        <= '0;
            r_imm_q       <= '0;
            r_rs1_q       <= '0;
            r_rs2_q       <= '0;
            r_rd_q        <= '0;
            r_alu_sel1_q  <= '0;
            r_alu_sel2_q  <= '0;
            r_alu_ctrl_q  <= '0;
            r_reg_write_q <= 1'b0;
            r_mem_read_q  <= 1'b0;
            r_mem_write_q <= 1'b0;
            r_res_src_q   <= '0;
            r_valid_q     <= 1'b0;
        end else begin
            r_pc_q        <= w_pc_d;
            r_imm_q       <= w_imm_d;
            r_rs1_q       <= w_rs1_d;
            r_rs2_q       <= w_rs2_d;
            r_rd_q        <= w_rd_d;
            r_alu_sel1_q  <= w_alu_sel1_d;
            r_alu_sel2_q  <= w_alu_sel2_d;
            r_alu_ctrl_q  <= w_alu_ctrl_d;
            r_reg_write_q <= w_reg_write_d;
            r_mem_read_q  <= w_mem_read_d;
            r_mem_write_q <= w_mem_write_d;
            r_res_src_q   <= w_res_src_d;
            r_valid_q     <= w_valid_d;
        end
    end

    // The instruction now in EX is the one that will sit in MEM next cycle
    fwd_select_reg #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (stall_ID_EX),
        .i_flush         (flush_ID_EX),
        .i_rs            (rs1_ID),
        .i_rd_data       (RD1D),
        .i_rd_ex         (r_rd_q),
        .i_reg_write_ex  (r_reg_write_q),
        .i_rd_mem        (rd_EX_MEM_o),
        .i_reg_write_mem (reg_write_EX_MEM_o),
        .i_result_wb     (result_WB),
        .o_fwd_sel       (forward_detect_EX_rs1),
        .o_rd_data       (RD1D_ID_EX_o)
    );

    fwd_select_reg #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (stall_ID_EX),
        .i_flush         (flush_ID_EX),
        .i_rs            (rs2_ID),
        .i_rd_data       (RD2D),
        .i_rd_ex         (r_rd_q),
        .i_reg_write_ex  (r_reg_write_q),
        .i_rd_mem        (rd_EX_MEM_o),
        .i_reg_write_mem (reg_write_EX_MEM_o),
        .i_result_wb     (result_WB),
        .o_fwd_sel       (forward_detect_EX_rs2),
        .o_rd_data       (RD2D_ID_EX_o)
    );

    assign PC_ID_EX_o          = r_pc_q;
    assign imm_ID_EX_o         = r_imm_q;
    assign rs1_ID_EX_o         = r_rs1_q;
    assign rs2_ID_EX_o         = r_rs2_q;
    assign rd_ID_EX_o          = r_rd_q;
    assign alu_sel_rs1_ID_EX_o = r_alu_sel1_q;
    assign alu_sel_rs2_ID_EX_o = r_alu_sel2_q;
    assign alu_ctrl_ID_EX_o    = r_alu_ctrl_q;
    assign reg_write_ID_EX_o   = r_reg_write_q;
    assign mem_read_ID_EX_o    = r_mem_read_q;
    assign mem_write_ID_EX_o   = r_mem_write_q;
    assign result_src_ID_EX_o  = r_res_src_q;
    assign valid_ID_EX_o       = r_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Scoreboard bench for id_ex_pipe_reg with a distance-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush;
    logic [31:0] pc, rd1, rd2, imm, wb;
    logic [4:0]  rs1, rs2, rd, rd_mem;
    logic [1:0]  as1, as2, rsrc;
    logic [3:0]  aluc;
    logic        rw, mr, mw, valid, we_mem;

    logic [31:0] o_pc, o_rd1, o_rd2, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [1:0]  o_as1, o_as2, o_rsrc;
    logic [3:0]  o_aluc;
    logic        o_rw, o_mr, o_mw, o_valid;
    logic [2:0]  o_f1, o_f2;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .stall_ID_EX(stall), .flush_ID_EX(flush),
        .PC_IF_ID_o(pc), .RD1D(rd1), .RD2D(rd2), .imm_ID(imm),
        .rs1_ID(rs1), .rs2_ID(rs2), .rd_ID(rd),
        .alu_sel_rs1_ID(as1), .alu_sel_rs2_ID(as2), .alu_ctrl_ID(aluc),
        .reg_write_ID(rw), .mem_read_ID(mr), .mem_write_ID(mw),
        .result_src_ID(rsrc), .valid_ID(valid),
        .rd_EX_MEM_o(rd_mem), .reg_write_EX_MEM_o(we_mem), .result_WB(wb),
        .PC_ID_EX_o(o_pc), .RD1D_ID_EX_o(o_rd1), .RD2D_ID_EX_o(o_rd2), .imm_ID_EX_o(o_imm),
        .rs1_ID_EX_o(o_rs1), .rs2_ID_EX_o(o_rs2), .rd_ID_EX_o(o_rd),
        .alu_sel_rs1_ID_EX_o(o_as1), .alu_sel_rs2_ID_EX_o(o_as2),
        .alu_ctrl_ID_EX_o(o_aluc),
        .reg_write_ID_EX_o(o_rw), .mem_read_ID_EX_o(o_mr), .mem_write_ID_EX_o(o_mw),
        .valid_ID_EX_o(o_valid), .result_src_ID_EX_o(o_rsrc),
        .forward_detect_EX_rs1(o_f1), .forward_detect_EX_rs2(o_f2)
    );

    typedef struct {
        logic        rst, stall, flush;
        logic [31:0] pc, rd1, rd2, imm, wb;
        logic [4:0]  rs1, rs2, rd, rd_mem;
        logic [1:0]  as1, as2, rsrc;
        logic [3:0]  aluc;
        logic        rw, mr, mw, valid, we_mem;
    } stim_t;

    typedef struct {
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [1:0]  as1, as2, rsrc;
        logic [3:0]  aluc;
        logic        rw, mr, mw, valid;
        logic [2:0]  f1, f2;
    } exp_t;

    exp_t expq[$];
    exp_t m;
    int   dist1, dist2;   // 0: no producer, 1: producer in MEM, 2: producer in WB
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst    = ($urandom_range(0, 49) == 0);
        s.flush  = ($urandom_range(0, 9) == 0);
        s.stall  = ($urandom_range(0, 3) == 0);
        s.pc     = $urandom; s.rd1 = $urandom; s.rd2 = $urandom;
        s.imm    = $urandom; s.wb  = $urandom;
        s.rs1    = 5'($urandom_range(0, 3));
        s.rs2    = 5'($urandom_range(0, 3));
        s.rd     = 5'($urandom_range(0, 3));
        s.rd_mem = 5'($urandom_range(0, 3));
        s.as1    = 2'($urandom_range(0, 2));
        s.as2    = 2'($urandom_range(0, 2));
        s.rsrc   = 2'($urandom);
        s.aluc   = 4'($urandom);
        s.rw     = 1'($urandom); s.mr = 1'($urandom); s.mw = 1'($urandom);
        s.valid  = 1'($urandom); s.we_mem = 1'($urandom);
        return s;
    endfunction

    function automatic int producer_dist(input logic [4:0] rs, input stim_t s);
        if (rs == 0) return 0;
        if (m.rw && m.rd == rs) return 1;
        if (s.we_mem && s.rd_mem == rs) return 2;
        return 0;
    endfunction

    task automatic model_step(input stim_t s);
        int n1, n2;
        if (s.rst || s.flush) begin
            m = '{default: '0};
            dist1 = 0;
            dist2 = 0;
        end else if (s.stall) begin
            // One stage further down; a WB producer retires into the held operand
            if (dist1 == 2) begin m.rd1 = s.wb; dist1 = 0; end
            else if (dist1 == 1) dist1 = 2;
            if (dist2 == 2) begin m.rd2 = s.wb; dist2 = 0; end
            else if (dist2 == 1) dist2 = 2;
        end else begin
            n1 = producer_dist(s.rs1, s);
            n2 = producer_dist(s.rs2, s);
            dist1 = n1; dist2 = n2;
            m.pc = s.pc; m.rd1 = s.rd1; m.rd2 = s.rd2; m.imm = s.imm;
            m.rs1 = s.rs1; m.rs2 = s.rs2; m.rd = s.rd;
            m.as1 = s.as1; m.as2 = s.as2; m.rsrc = s.rsrc; m.aluc = s.aluc;
            m.rw = s.rw; m.mr = s.mr; m.mw = s.mw; m.valid = s.valid;
        end
        m.f1 = 3'(1 << dist1);
        m.f2 = 3'(1 << dist2);
    endtask

    task automatic apply(input stim_t s);
        @(negedge clk);
        rst = s.rst; stall = s.stall; flush = s.flush;
        pc = s.pc; rd1 = s.rd1; rd2 = s.rd2; imm = s.imm; wb = s.wb;
        rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; rd_mem = s.rd_mem;
        as1 = s.as1; as2 = s.as2; rsrc = s.rsrc; aluc = s.aluc;
        rw = s.rw; mr = s.mr; mw = s.mw; valid = s.valid; we_mem = s.we_mem;
        model_step(s);
        expq.push_back(m);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pc",   64'(o_pc),  64'(e.pc));
                chk("rd1",  64'(o_rd1), 64'(e.rd1));
                chk("rd2",  64'(o_rd2), 64'(e.rd2));
                chk("imm",  64'(o_imm), 64'(e.imm));
                chk("idx",  64'({o_rs1, o_rs2, o_rd}), 64'({e.rs1, e.rs2, e.rd}));
                chk("ctrl", 64'({o_as1, o_as2, o_aluc, o_rw, o_mr, o_mw, o_rsrc, o_valid}),
                            64'({e.as1, e.as2, e.aluc, e.rw, e.mr, e.mw, e.rsrc, e.valid}));
                chk("fwd1", 64'(o_f1), 64'(e.f1));
                chk("fwd2", 64'(o_f2), 64'(e.f2));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        {rst, stall, flush, rw, mr, mw, valid, we_mem} = '0;
        {pc, rd1, rd2, imm, wb} = '0;
        {rs1, rs2, rd, rd_mem, as1, as2, rsrc, aluc} = '0;
        m = '{default: '0};
        dist1 = 0; dist2 = 0;

        // Reset for two cycles
        s = idle(); s.rst = 1'b1;
        apply(s); apply(s);

        // Back-to-back dependency through x5, rs2 = x0
        s = rnd(); s.rst = 0; s.flush = 0; s.stall = 0; s.we_mem = 0;
        s.rd = 5; s.rw = 1; s.rs1 = 0; s.rs2 = 0;
        apply(s);
        s = rnd(); s.rst = 0; s.flush = 0; s.stall = 0; s.we_mem = 0;
        s.rs1 = 5; s.rs2 = 0; s.rd = 6; s.rw = 1;
        apply(s);

        // Distance-2 dependency on x7
        s = rnd(); s.rst = 0; s.flush = 0; s.stall = 0;
        s.rs1 = 1; s.rs2 = 7; s.rd_mem = 7; s.we_mem = 1; s.rd = 9; s.rw = 1;
        apply(s);

        // Stall aging with a WB refresh on the second stall cycle
        s = rnd(); s.rst = 0; s.flush = 0; s.stall = 0; s.we_mem = 0;
        s.rs1 = 9; s.rs2 = 3;
        apply(s);
        s = rnd(); s.rst = 0; s.flush = 0; s.stall = 1;
        apply(s);
        s.wb = 32'hDEAD_BEEF;
        apply(s);
        apply(s);

        // Flush together with stall
        s = rnd(); s.rst = 0; s.flush = 1; s.stall = 1;
        apply(s);

        // Reset arriving during a stall, then a normal dependent load
        s = rnd(); s.rst = 0; s.flush = 0; s.stall = 0; s.rd = 4; s.rw = 1;
        apply(s);
        s = rnd(); s.rst = 0; s.flush = 0; s.stall = 0; s.rs1 = 4; s.rs2 = 4;
        apply(s);
        s = rnd(); s.rst = 1; s.stall = 1; s.flush = 0;
        apply(s);
        s = rnd(); s.rst = 0; s.flush = 0; s.stall = 0; s.rs1 = 2; s.rd_mem = 2; s.we_mem = 1;
        apply(s);

        for (int i = 0; i < 400; i++) begin
            apply(rnd());
        end

        s = idle();
        apply(s);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (expq.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0 pending", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register for the 5-stage RISC-V core. It latches decoded operands and control from ID and presents them to the EX stage, including the rs1/rs2 operand muxes. It precomputes registered one-hot forwarding selects (forward_detect_EX_rs1/rs2) one cycle early, so EX sees no comparator path. It supports stall (hold) and flush (bubble), and keeps the forwarding selects and held operands correct while holding.

Parameters:
DATA_WIDTH, 32, datapath width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
stall_ID_EX  in  1  hold current contents
flush_ID_EX  in  1  load bubble
PC_IF_ID_o  in  DATA_WIDTH  PC of instruction in ID
RD1D  in  DATA_WIDTH  regfile read data rs1
RD2D  in  DATA_WIDTH  regfile read data rs2
imm_ID  in  DATA_WIDTH  decoded immediate
rs1_ID, rs2_ID, rd_ID  in  REG_ADDR_WIDTH  register indices
alu_sel_rs1_ID, alu_sel_rs2_ID  in  2  operand selects (0 reg, 1 PC/imm, 2 zero)
alu_ctrl_ID  in  4  ALU op
reg_write_ID, mem_read_ID, mem_write_ID  in  1  control
result_src_ID  in  2  WB source select
valid_ID  in  1  instruction valid
rd_EX_MEM_o  in  REG_ADDR_WIDTH  rd of instruction in MEM
reg_write_EX_MEM_o  in  1  MEM-stage write enable
result_WB  in  DATA_WIDTH  WB write data
PC_ID_EX_o, RD1D_ID_EX_o, RD2D_ID_EX_o, imm_ID_EX_o  out  DATA_WIDTH  registered copies
rs1_ID_EX_o, rs2_ID_EX_o, rd_ID_EX_o  out  REG_ADDR_WIDTH
alu_sel_rs1_ID_EX_o, alu_sel_rs2_ID_EX_o  out  2
alu_ctrl_ID_EX_o  out  4
reg_write_ID_EX_o, mem_read_ID_EX_o, mem_write_ID_EX_o, valid_ID_EX_o  out  1
result_src_ID_EX_o  out  2
forward_detect_EX_rs1, forward_detect_EX_rs2  out  3  one-hot {IN_WB, IN_MEM, NONE}

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: all outputs 0, except forward_detect_* = 3'b001 (NONE).
- Priority is rst > flush > stall > load. Latency is 1 cycle from ID inputs to outputs.
- Load (no stall, no flush): all fields are captured. For each operand rsN:
  - IN_MEM is set if reg_write_ID_EX_o && rd_ID_EX_o != 0 && rd_ID_EX_o == rsN_ID. The current EX instruction moves to MEM.
  - Otherwise IN_WB is set if reg_write_EX_MEM_o && rd_EX_MEM_o != 0 && rd_EX_MEM_o == rsN_ID.
  - Otherwise NONE is set.
  - rsN_ID == 0 always gives NONE.
- Flush: bubble. All control, valid and indices are 0; data fields are 0; forward_detect = NONE. Flush overrides a simultaneous stall.
- Stall: all fields hold. The hazard unit inserts a bubble into EX/MEM whenever stall_ID_EX is asserted, so downstream advances and the selects age:
  - new IN_WB = old IN_MEM
  - new IN_MEM = 0
  - new NONE = !old IN_MEM
  - If old IN_WB was set, the WB result retires this cycle: RDnD_ID_EX_o <= result_WB (operand refresh) and the select becomes NONE unless old IN_MEM.
  - A multi-cycle stall converges to NONE within 2 cycles.
- Load-use stalls are decided by the hazard unit, not here. The regfile is write-first, so same-cycle WB→ID needs no select.
- The forward_detect outputs are always exactly one-hot.

Decomposition:
- Shared package/defines: FORWARD_NO_COLLISION=0, FORWARD_COLLISION_IN_MEM=1, FORWARD_COLLISION_IN_WB=2 (bit indices); ALU_SEL_* encodings; reset select constant 3'b001.
- Sub-module fwd_select_reg: per-operand select register with its load/flush/stall-age/refresh logic and held operand data. It is instantiated twice (rs1, rs2).

Test Plan:
1. Reset with rst=1 for 2 cycles, then check outputs → all 0, forward_detect_EX_rs1 = forward_detect_EX_rs2 = 3'b001.
2. Back-to-back dependency: `addi x5,…` then `add x6,x5,x0` → on the second load forward_detect_EX_rs1 = 3'b010; rs2 (x0) = 3'b001.
3. Distance-2 dependency: rd_EX_MEM_o=7, reg_write_EX_MEM_o=1, rs2_ID=7 → forward_detect_EX_rs2 = 3'b100.
4. Stall aging: load with rs1 IN_MEM, then stall 2 cycles with result_WB=0xDEADBEEF in cycle 2 → rs1 select goes 010→100→001, and RD1D_ID_EX_o = 0xDEADBEEF after cycle 2.
5. Flush with stall asserted simultaneously → valid=0, reg_write=0, forward_detect=001 next cycle.
6. Mid-operation rst during stall → all outputs reset next cycle; the following load behaves normally.
